// File: rtl/dcache_flush_walker_pkg.sv
// rtl/dcache_flush_walker_pkg.sv - shared dcache flush walker types and parameters
package dcache_flush_walker_pkg;

    localparam int unsigned DCACHE_NUM_SETS = 256;
    localparam int unsigned DCACHE_NUM_WAYS = 8;
    localparam int unsigned DCACHE_TAG_W    = 44;
    localparam int unsigned DCACHE_LINE_W   = 128;

    // One way of the tag array as it appears on the tag read port
    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [DCACHE_TAG_W-1:0] tag;
    } dcache_meta_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_TAG,
        S_WT_TAG,
        S_SCAN,
        S_RD_DATA,
        S_WT_DATA,
        S_WB,
        S_INVAL,
        S_DONE
    } walk_state_e;

endpackage

// File: rtl/dcache_flush_walker_lzc.sv
// rtl/dcache_flush_walker_lzc.sv - trailing-zero counter picking the lowest set bit
module dcache_flush_walker_lzc #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // Scan from the top so the lowest set bit wins
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_walker.sv
// rtl/dcache_flush_walker.sv - write-back dcache flush engine walking every set and way
module dcache_flush_walker
    import dcache_flush_walker_pkg::*;
#(
    parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
    parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS,
    parameter int unsigned TAG_W    = DCACHE_TAG_W,
    parameter int unsigned LINE_W   = DCACHE_LINE_W,
    localparam int unsigned IDX_W   = $clog2(NUM_SETS),
    localparam int unsigned OFF_W   = $clog2(LINE_W / 8),
    localparam int unsigned WAY_W   = $clog2(NUM_WAYS),
    localparam int unsigned META_W  = TAG_W + 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        flush_i,
    output logic                        flush_ack_o,
    output logic                        busy_o,
    output logic                        tag_req_o,
    output logic                        tag_we_o,
    output logic [IDX_W-1:0]            tag_idx_o,
    input  logic                        tag_gnt_i,
    input  logic                        tag_rvalid_i,
    input  logic [NUM_WAYS*META_W-1:0]  tag_rdata_i,
    output logic                        data_req_o,
    output logic [IDX_W-1:0]            data_idx_o,
    output logic [NUM_WAYS-1:0]         data_way_o,
    input  logic                        data_gnt_i,
    input  logic                        data_rvalid_i,
    input  logic [LINE_W-1:0]           data_rdata_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [TAG_W+IDX_W+OFF_W-1:0] wb_addr_o,
    output logic [LINE_W-1:0]           wb_data_o
);

    walk_state_e                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_WAYS-1:0]            mask_q, mask_d;
    logic [WAY_W-1:0]               way_q, way_d;
    logic [NUM_WAYS-1:0][TAG_W-1:0] tags_q, tags_d;
    logic [LINE_W-1:0]              line_q, line_d;
    logic [WAY_W-1:0]               lzc_cnt;
    logic                           lzc_empty;
    logic                           last_set;

    dcache_flush_walker_lzc #(
        .WIDTH (NUM_WAYS)
    ) i_lzc (
        .in_i    (mask_q),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    // The walk ends on the last set instead of letting the index wrap
    assign last_set = (idx_q == IDX_W'(NUM_SETS - 1));

    // Walker sequencing: read tags, write back dirty ways lowest first, invalidate the set
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        way_d       = way_q;
        tags_d      = tags_q;
        line_d      = line_q;
        tag_req_o   = 1'b0;
        tag_we_o    = 1'b0;
        data_req_o  = 1'b0;
        wb_valid_o  = 1'b0;
        flush_ack_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    idx_d   = '0;
                    state_d = S_RD_TAG;
                end
            end
            S_RD_TAG: begin
                tag_req_o = 1'b1;
                if (tag_gnt_i) begin
                    state_d = S_WT_TAG;
                end
            end
            S_WT_TAG: begin
                if (tag_rvalid_i) begin
                    for (int w = 0; w < int'(NUM_WAYS); w++) begin
                        tags_d[w] = tag_rdata_i[w*META_W +: TAG_W];
                        mask_d[w] = tag_rdata_i[w*META_W + TAG_W + 1] & tag_rdata_i[w*META_W + TAG_W];
                    end
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (lzc_empty) begin
                    state_d = S_INVAL;
                end else begin
                    way_d   = lzc_cnt;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    state_d = S_WT_DATA;
                end
            end
            S_WT_DATA: begin
                if (data_rvalid_i) begin
                    line_d  = data_rdata_i;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    mask_d[way_q] = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_INVAL: begin
                tag_req_o = 1'b1;
                tag_we_o  = 1'b1;
                if (tag_gnt_i) begin
                    if (last_set) begin
                        flush_ack_o = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_TAG;
                    end
                end
            end
            S_DONE: begin
                // The controller's registered flush is still high right after ack
                if (!flush_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Walker registers; clr_i behaves exactly like reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            way_q   <= '0;
            tags_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            way_q   <= way_d;
            tags_q  <= tags_d;
            line_q  <= line_d;
        end
    end

    assign tag_idx_o  = idx_q;
    assign data_idx_o = idx_q;
    assign data_way_o = (state_q == S_RD_DATA) ? (NUM_WAYS'(1) << way_q) : '0;
    assign wb_addr_o  = {tags_q[way_q], idx_q, {OFF_W{1'b0}}};
    assign wb_data_o  = line_q;
    assign busy_o     = (state_q != S_IDLE) | wb_valid_o;

endmodule

// File: tb/tb_dcache_flush_walker.sv
// tb/tb_dcache_flush_walker.sv - self-checking bench for dcache_flush_walker
`timescale 1ns/1ps
module tb_dcache_flush_walker;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 8;
    localparam int TAG_W    = 44;
    localparam int LINE_W   = 128;
    localparam int IDX_W    = 2;
    localparam int OFF_W    = 4;
    localparam int META_W   = TAG_W + 2;
    localparam int ADDR_W   = TAG_W + IDX_W + OFF_W;

    logic                        clk;
    logic                        rst_ni;
    logic                        clr_i;
    logic                        flush_i;
    logic                        flush_ack_o;
    logic                        busy_o;
    logic                        tag_req_o;
    logic                        tag_we_o;
    logic [IDX_W-1:0]            tag_idx_o;
    logic                        tag_gnt_i;
    logic                        tag_rvalid_i;
    logic [NUM_WAYS*META_W-1:0]  tag_rdata_i;
    logic                        data_req_o;
    logic [IDX_W-1:0]            data_idx_o;
    logic [NUM_WAYS-1:0]         data_way_o;
    logic                        data_gnt_i;
    logic                        data_rvalid_i;
    logic [LINE_W-1:0]           data_rdata_i;
    logic                        wb_valid_o;
    logic                        wb_ready_i;
    logic [ADDR_W-1:0]           wb_addr_o;
    logic [LINE_W-1:0]           wb_data_o;

    dcache_flush_walker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clr_i         (clr_i),
        .flush_i       (flush_i),
        .flush_ack_o   (flush_ack_o),
        .busy_o        (busy_o),
        .tag_req_o     (tag_req_o),
        .tag_we_o      (tag_we_o),
        .tag_idx_o     (tag_idx_o),
        .tag_gnt_i     (tag_gnt_i),
        .tag_rvalid_i  (tag_rvalid_i),
        .tag_rdata_i   (tag_rdata_i),
        .data_req_o    (data_req_o),
        .data_idx_o    (data_idx_o),
        .data_way_o    (data_way_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cache array model
    bit                m_valid [NUM_SETS][NUM_WAYS];
    bit                m_dirty [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  m_tag   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] m_data  [NUM_SETS][NUM_WAYS];

    // Scoreboard
    logic [ADDR_W-1:0] exp_addr[$];
    logic [LINE_W-1:0] exp_data[$];
    int                exp_inval[$];
    int                obs_tag_rd[$];

    int checks = 0;
    int errors = 0;

    // Responder knobs and observations
    int  tag_inval_last_delay = 0;
    int  wb_stall = 0;
    bit  tag_pend;
    int  tag_pend_idx;
    bit  data_pend;
    int  data_pend_set, data_pend_way;
    int  tag_wait, tdelay, wb_hold, exp_i;
    logic [ADDR_W-1:0] wb_addr_first, ea;
    logic [LINE_W-1:0] wb_data_first, ed;
    int  stall_seen, stab_err, req_in_wb, last_wait, ack_count, wb_seen;
    bit  ack_gnt_ok;

    function automatic logic [NUM_WAYS*META_W-1:0] pack_set(input int s);
        logic [NUM_WAYS*META_W-1:0] r;
        r = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            r[w*META_W +: META_W] = {m_valid[s][w], m_dirty[s][w], m_tag[s][w]};
        return r;
    endfunction

    // Tag/data arrays and writeback buffer, plus the writeback/invalidate scoreboard
    initial begin
        tag_gnt_i = 0; tag_rvalid_i = 0; tag_rdata_i = '0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
        wb_ready_i = 0;
        forever begin
            @(negedge clk);
            tag_rvalid_i  = tag_pend;
            tag_rdata_i   = tag_pend ? pack_set(tag_pend_idx) : '0;
            tag_pend      = 0;
            data_rvalid_i = data_pend;
            data_rdata_i  = data_pend ? m_data[data_pend_set][data_pend_way] : '0;
            data_pend     = 0;

            tag_gnt_i = 0;
            if (tag_req_o) begin
                tdelay = (tag_we_o && int'(tag_idx_o) == NUM_SETS - 1) ? tag_inval_last_delay : 0;
                if (tag_wait >= tdelay) begin
                    tag_gnt_i = 1;
                    tag_wait  = 0;
                    if (tag_we_o) begin
                        checks++;
                        if (exp_inval.size() == 0) begin
                            errors++;
                            $display("FAIL inval_order: got idx %0d, expected no invalidate", tag_idx_o);
                        end else begin
                            exp_i = exp_inval.pop_front();
                            if (int'(tag_idx_o) != exp_i) begin
                                errors++;
                                $display("FAIL inval_order: got idx %0d, expected %0d", tag_idx_o, exp_i);
                            end
                        end
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            m_valid[tag_idx_o][w] = 0;
                            m_dirty[tag_idx_o][w] = 0;
                        end
                    end else begin
                        tag_pend     = 1;
                        tag_pend_idx = int'(tag_idx_o);
                        obs_tag_rd.push_back(int'(tag_idx_o));
                    end
                end else begin
                    tag_wait++;
                    if (tag_we_o && int'(tag_idx_o) == NUM_SETS - 1) last_wait++;
                end
            end else begin
                tag_wait = 0;
            end

            data_gnt_i = 0;
            if (data_req_o) begin
                data_gnt_i    = 1;
                data_pend     = 1;
                data_pend_set = int'(data_idx_o);
                for (int w = 0; w < NUM_WAYS; w++)
                    if (data_way_o[w]) data_pend_way = w;
            end

            wb_ready_i = 0;
            if (wb_valid_o) begin
                if (wb_hold == 0) begin
                    wb_addr_first = wb_addr_o;
                    wb_data_first = wb_data_o;
                end else if (wb_addr_o !== wb_addr_first || wb_data_o !== wb_data_first) begin
                    stab_err++;
                end
                if (tag_req_o || data_req_o) req_in_wb++;
                if (wb_hold >= wb_stall) begin
                    wb_ready_i = 1;
                    wb_hold    = 0;
                    wb_seen++;
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL wb_order: got addr %h, expected no writeback", wb_addr_o);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        if (wb_addr_o !== ea || wb_data_o !== ed) begin
                            errors++;
                            $display("FAIL wb_order: got addr %h data %h, expected addr %h data %h",
                                     wb_addr_o, wb_data_o, ea, ed);
                        end
                    end
                end else begin
                    wb_hold++;
                    stall_seen++;
                end
            end else begin
                wb_hold = 0;
            end

            #1;
            if (flush_ack_o) begin
                ack_count++;
                ack_gnt_ok = tag_gnt_i && tag_req_o && tag_we_o && (int'(tag_idx_o) == NUM_SETS - 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic clear_model();
        logic [63:0] r;
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
                r = {$urandom(), $urandom()};
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = r[TAG_W-1:0];
                m_data[s][w]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
    endtask

    task automatic start_flush();
        logic [IDX_W-1:0] si;
        exp_addr.delete(); exp_data.delete(); exp_inval.delete(); obs_tag_rd.delete();
        for (int s = 0; s < NUM_SETS; s++) begin
            si = IDX_W'(s);
            for (int w = 0; w < NUM_WAYS; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    exp_addr.push_back({m_tag[s][w], si, {OFF_W{1'b0}}});
                    exp_data.push_back(m_data[s][w]);
                end
            exp_inval.push_back(s);
        end
        ack_count = 0; ack_gnt_ok = 0; wb_seen = 0;
        stall_seen = 0; stab_err = 0; req_in_wb = 0; last_wait = 0;
        flush_i = 1;
    endtask

    task automatic wait_ack(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk); #2;
            if (ack_count != 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic end_flush();
        @(negedge clk); #2;
        flush_i = 0;
        @(negedge clk); #2;
    endtask

    task automatic test_reset();
        rst_ni = 0; clr_i = 0; flush_i = 0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({tag_req_o, tag_we_o, data_req_o, wb_valid_o, busy_o, flush_ack_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {tag_req_o, tag_we_o, data_req_o, wb_valid_o, busy_o, flush_ack_o});
        end
        checks++;
        if (tag_idx_o !== '0 || data_idx_o !== '0 || data_way_o !== '0) begin
            errors++;
            $display("FAIL reset_idx: got %h %h %h, expected 0 0 0", tag_idx_o, data_idx_o, data_way_o);
        end
        checks++;
        if (wb_addr_o !== '0 || wb_data_o !== '0) begin
            errors++;
            $display("FAIL reset_wb: got %h %h, expected 0 0", wb_addr_o, wb_data_o);
        end
        rst_ni = 1;
        @(negedge clk); #2;
    endtask

    task automatic test_clean();
        bit ok;
        clear_model();
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_ack: got no ack, expected ack"); end
        checks++;
        if (wb_seen != 0) begin errors++; $display("FAIL clean_wb: got %0d writebacks, expected 0", wb_seen); end
        checks++;
        if (exp_inval.size() != 0) begin
            errors++; $display("FAIL clean_inval: got %0d missing invalidates, expected 0", exp_inval.size());
        end
        @(negedge clk); #2;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL clean_busy_done: got %b, expected 1", busy_o); end
        flush_i = 0;
        @(negedge clk); #2;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL clean_busy_idle: got %b, expected 0", busy_o); end
        checks++;
        if (ack_count != 1) begin errors++; $display("FAIL clean_ack_count: got %0d, expected 1", ack_count); end
    endtask

    task automatic test_dirty_ways();
        bit ok;
        clear_model();
        m_valid[2][1] = 1; m_dirty[2][1] = 1; m_tag[2][1] = 44'h123;
        m_valid[2][5] = 1; m_dirty[2][5] = 1; m_tag[2][5] = 44'h123;
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok || wb_seen != 2 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL dirty_ways: got ack %0d wb %0d left %0d, expected 1 2 0", ok, wb_seen, exp_addr.size());
        end
        end_flush();
    endtask

    task automatic test_wb_stall();
        bit ok;
        clear_model();
        m_valid[1][3] = 1; m_dirty[1][3] = 1;
        wb_stall = 10;
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok || stall_seen != 10 || wb_seen != 1) begin
            errors++;
            $display("FAIL wb_stall_len: got ack %0d stall %0d wb %0d, expected 1 10 1", ok, stall_seen, wb_seen);
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL wb_stable: got %0d changes, expected 0", stab_err); end
        checks++;
        if (req_in_wb != 0) begin errors++; $display("FAIL wb_no_req: got %0d requests, expected 0", req_in_wb); end
        wb_stall = 0;
        end_flush();
    endtask

    task automatic test_last_inval_delay();
        bit ok;
        int rd_before, bad;
        clear_model();
        m_valid[3][0] = 1; m_dirty[3][0] = 1;
        tag_inval_last_delay = 5;
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok || !ack_gnt_ok || last_wait != 5) begin
            errors++;
            $display("FAIL ack_at_grant: got ack %0d at_gnt %0d wait %0d, expected 1 1 5", ok, ack_gnt_ok, last_wait);
        end
        tag_inval_last_delay = 0;
        rd_before = obs_tag_rd.size();
        bad = 0;
        repeat (3) begin
            @(negedge clk); #2;
            if (tag_req_o || data_req_o || !busy_o) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL no_restart_hold: got %0d bad cycles, expected 0", bad); end
        flush_i = 0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (busy_o !== 1'b0 || obs_tag_rd.size() != rd_before || ack_count != 1) begin
            errors++;
            $display("FAIL no_restart_idle: got busy %b reads %0d acks %0d, expected 0 %0d 1",
                     busy_o, obs_tag_rd.size(), ack_count, rd_before);
        end
    endtask

    task automatic test_clr_in_wb();
        bit ok, seen;
        clear_model();
        m_valid[2][6] = 1; m_dirty[2][6] = 1;
        wb_stall = 50;
        start_flush();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (wb_valid_o) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL clr_reach_wb: got no wb_valid, expected wb_valid"); end
        clr_i = 1; flush_i = 0;
        @(negedge clk); #2;
        checks++;
        if ({wb_valid_o, tag_req_o, data_req_o, busy_o} !== 4'b0) begin
            errors++;
            $display("FAIL clr_idle: got %b, expected 0000", {wb_valid_o, tag_req_o, data_req_o, busy_o});
        end
        clr_i = 0;
        wb_stall = 0;
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok || obs_tag_rd.size() == 0 || obs_tag_rd[0] != 0 || wb_seen != 1) begin
            errors++;
            $display("FAIL clr_restart: got ack %0d first_idx %0d wb %0d, expected 1 0 1",
                     ok, (obs_tag_rd.size() != 0) ? obs_tag_rd[0] : -1, wb_seen);
        end
        end_flush();
    endtask

    task automatic test_clean_variants();
        bit ok;
        clear_model();
        m_valid[1][0] = 1; m_dirty[1][0] = 0;
        m_valid[1][4] = 0; m_dirty[1][4] = 1;
        m_valid[3][7] = 1; m_dirty[3][7] = 1;
        start_flush();
        wait_ack(400, ok);
        checks++;
        if (!ok || wb_seen != 1 || exp_addr.size() != 0 || exp_inval.size() != 0) begin
            errors++;
            $display("FAIL clean_variants: got ack %0d wb %0d left %0d/%0d, expected 1 1 0/0",
                     ok, wb_seen, exp_addr.size(), exp_inval.size());
        end
        end_flush();
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            clear_model();
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++) begin
                    m_valid[s][w] = 1'($urandom_range(0, 1));
                    m_dirty[s][w] = 1'($urandom_range(0, 1));
                end
            start_flush();
            wait_ack(2000, ok);
            checks++;
            if (!ok || exp_addr.size() != 0 || exp_inval.size() != 0 || ack_count != 1) begin
                errors++;
                $display("FAIL random_walk_%0d: got ack %0d left %0d/%0d acks %0d, expected 1 0/0 1",
                         r, ok, exp_addr.size(), exp_inval.size(), ack_count);
            end
            end_flush();
        end
    endtask

    initial begin
        rst_ni = 0; clr_i = 0; flush_i = 0;
        test_reset();
        test_clean();
        test_dirty_ways();
        test_wb_stall();
        test_last_inval_delay();
        test_clr_in_wb();
        test_clean_variants();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
